// File: rtl/mole_game_ctrl.sv
// Whack-a-mole game controller: picks the mole hole from an LFSR, times the
// up/gap phases, scores hits, handles pause and drives the display stage.
module mole_game_ctrl #(
  parameter int unsigned UP_CYCLES  = 50_000_000,
  parameter int unsigned GAP_CYCLES = 12_500_000,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic [4:0] hit_btn,
  input  logic       timer_done,
  output logic [2:0] oval_select,
  output logic [3:0] score,
  output logic       enable,
  output logic       pause,
  output logic       timer_clear,
  output logic       game_over
);

  typedef enum logic [2:0] {IDLE, SPAWN, UP, GAP, PAUSED, OVER} state_t;

  localparam logic [26:0] UP_LOAD  = 27'(UP_CYCLES - 1);
  localparam logic [26:0] GAP_LOAD = 27'(GAP_CYCLES - 1);

  state_t      state, state_nxt, resume_state, resume_nxt;
  logic [26:0] cnt, cnt_nxt;
  logic [7:0]  lfsr;
  logic [2:0]  prev_hole, prev_nxt, oval_nxt, cand, spawn_hole;
  logic [3:0]  score_nxt;
  logic        clear_nxt, enable_nxt, pause_nxt, over_nxt;
  logic        start_q, pause_q;
  logic [4:0]  hit_q, hit_edge, hole_mask;
  logic        start_edge, pause_edge, correct_hit;

  assign start_edge  = start_btn & ~start_q;
  assign pause_edge  = pause_btn & ~pause_q;
  assign hit_edge    = hit_btn & ~hit_q;
  assign correct_hit = |(hit_edge & hole_mask);

  // Candidate hole is remapped to the next one if it repeats the last spawn.
  assign cand       = 3'(lfsr % 8'd5) + 3'd1;
  assign spawn_hole = (cand != prev_hole) ? cand :
                      (cand == 3'd5)      ? 3'd1 : cand + 3'd1;

  always_comb begin
    case (oval_select)
      3'd1:    hole_mask = 5'b00001;
      3'd2:    hole_mask = 5'b00010;
      3'd3:    hole_mask = 5'b00100;
      3'd4:    hole_mask = 5'b01000;
      3'd5:    hole_mask = 5'b10000;
      default: hole_mask = 5'b00000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      resume_state <= IDLE;
      cnt          <= '0;
      lfsr         <= LFSR_SEED;
      prev_hole    <= '0;
      oval_select  <= '0;
      score        <= '0;
      enable       <= 1'b0;
      pause        <= 1'b0;
      timer_clear  <= 1'b0;
      game_over    <= 1'b0;
      start_q      <= 1'b0;
      pause_q      <= 1'b0;
      hit_q        <= '0;
    end else begin
      state        <= state_nxt;
      resume_state <= resume_nxt;
      cnt          <= cnt_nxt;
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      prev_hole    <= prev_nxt;
      oval_select  <= oval_nxt;
      score        <= score_nxt;
      enable       <= enable_nxt;
      pause        <= pause_nxt;
      timer_clear  <= clear_nxt;
      game_over    <= over_nxt;
      start_q      <= start_btn;
      pause_q      <= pause_btn;
      hit_q        <= hit_btn;
    end
  end

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt  = state;
    resume_nxt = resume_state;
    cnt_nxt    = cnt;
    oval_nxt   = oval_select;
    prev_nxt   = prev_hole;
    score_nxt  = score;
    clear_nxt  = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          score_nxt = '0;
          clear_nxt = 1'b1;
          state_nxt = SPAWN;
        end
      end
      SPAWN: begin
        oval_nxt  = spawn_hole;
        prev_nxt  = spawn_hole;
        cnt_nxt   = UP_LOAD;
        state_nxt = UP;
      end
      UP: begin
        if (timer_done) begin
          oval_nxt  = '0;
          state_nxt = OVER;
        end else if (pause_edge) begin
          resume_nxt = UP;
          state_nxt  = PAUSED;
        end else if (correct_hit || cnt == '0) begin
          if (correct_hit && score != 4'd15) score_nxt = score + 4'd1;
          oval_nxt  = '0;
          cnt_nxt   = GAP_LOAD;
          state_nxt = GAP;
        end else begin
          cnt_nxt = cnt - 27'd1;
        end
      end
      GAP: begin
        if (timer_done) begin
          state_nxt = OVER;
        end else if (pause_edge) begin
          resume_nxt = GAP;
          state_nxt  = PAUSED;
        end else if (cnt == '0) begin
          state_nxt = SPAWN;
        end else begin
          cnt_nxt = cnt - 27'd1;
        end
      end
      PAUSED: begin
        if (timer_done) begin
          oval_nxt  = '0;
          state_nxt = OVER;
        end else if (pause_edge) begin
          state_nxt = resume_state;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state so they register with it.
  always_comb begin
    enable_nxt = 1'b0;
    pause_nxt  = 1'b0;
    over_nxt   = 1'b0;
    case (state_nxt)
      SPAWN, UP, GAP: enable_nxt = 1'b1;
      PAUSED: begin
        enable_nxt = 1'b1;
        pause_nxt  = 1'b1;
      end
      OVER:    over_nxt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Self-checking bench for mole_game_ctrl with short up/gap timing; expected
// values are queued when stimulus is driven and compared when observed.
module tb_mole_game_ctrl;

  localparam int UP  = 8;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_btn = 1'b0;
  logic       pause_btn = 1'b0;
  logic [4:0] hit_btn = '0;
  logic       timer_done = 1'b0;
  logic [2:0] oval_select;
  logic [3:0] score;
  logic       enable, pause, timer_clear, game_over;

  int checks = 0;
  int failures = 0;
  int sb_q[$];
  int model_score = 0;

  mole_game_ctrl #(.UP_CYCLES(UP), .GAP_CYCLES(GAP), .LFSR_SEED(8'hA5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .hit_btn    (hit_btn),
    .timer_done (timer_done),
    .oval_select(oval_select),
    .score      (score),
    .enable     (enable),
    .pause      (pause),
    .timer_clear(timer_clear),
    .game_over  (game_over)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [4:0] hole_bit(input logic [2:0] h);
    return 5'd1 << (h - 3'd1);
  endfunction

  task automatic wait_oval(input bit nonzero, input string tag);
    int n = 0;
    while (((oval_select != 3'd0) != nonzero) && n < 100) begin
      tick();
      n++;
    end
    if ((oval_select != 3'd0) != nonzero) begin
      checks++;
      failures++;
      $display("FAIL %s: timed out, oval_select=%0d want nonzero=%0d", tag, oval_select, nonzero);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) tick();
    checks++; if (oval_select !== 3'd0) begin failures++; $display("FAIL reset_oval: got %0d want 0", oval_select); end
    checks++; if (score !== 4'd0)       begin failures++; $display("FAIL reset_score: got %0d want 0", score); end
    checks++; if (enable !== 1'b0)      begin failures++; $display("FAIL reset_enable: got %b want 0", enable); end
    checks++; if (pause !== 1'b0)       begin failures++; $display("FAIL reset_pause: got %b want 0", pause); end
    checks++; if (timer_clear !== 1'b0) begin failures++; $display("FAIL reset_clear: got %b want 0", timer_clear); end
    checks++; if (game_over !== 1'b0)   begin failures++; $display("FAIL reset_over: got %b want 0", game_over); end
    rst = 1'b1;
    repeat (3) tick();
    checks++; if ({enable, timer_clear, oval_select} !== 5'd0) begin
      failures++; $display("FAIL idle_quiet: enable=%b clear=%b oval=%0d want all 0", enable, timer_clear, oval_select);
    end
  endtask

  task automatic test_start_timing();
    int tc = 0, up_len = 0, gap_len = 0;
    logic [2:0] first;
    sb_q.push_back(1);
    sb_q.push_back(UP);
    sb_q.push_back(GAP + 1);
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    checks++; if (enable !== 1'b1 || timer_clear !== 1'b1 || oval_select !== 3'd0) begin
      failures++; $display("FAIL spawn_cycle: enable=%b clear=%b oval=%0d want 1 1 0", enable, timer_clear, oval_select);
    end
    tc += int'(timer_clear);
    tick();
    first = oval_select;
    checks++; if (first < 3'd1 || first > 3'd5) begin failures++; $display("FAIL first_hole: got %0d want 1..5", first); end
    while (oval_select == first && up_len < 50) begin tc += int'(timer_clear); up_len++; tick(); end
    while (oval_select == 3'd0 && gap_len < 50) begin tc += int'(timer_clear); gap_len++; tick(); end
    checks++; if (tc !== sb_q.pop_front()) begin failures++; $display("FAIL clear_width: got %0d want 1", tc); end
    checks++; if (up_len !== sb_q.pop_front()) begin failures++; $display("FAIL up_len: got %0d want %0d", up_len, UP); end
    checks++; if (gap_len !== sb_q.pop_front()) begin failures++; $display("FAIL gap_len: got %0d want %0d", gap_len, GAP + 1); end
    checks++; if (oval_select == first || oval_select == 3'd0) begin
      failures++; $display("FAIL second_hole: got %0d want nonzero and != %0d", oval_select, first);
    end
  endtask

  // Entered on the first sample of an UP phase.
  task automatic test_hit();
    logic [2:0] h, other;
    h = oval_select;
    other = (h == 3'd5) ? 3'd1 : h + 3'd1;
    tick();
    hit_btn = hole_bit(other);
    tick();
    hit_btn = '0;
    checks++; if (oval_select !== h || score !== 4'd0) begin
      failures++; $display("FAIL wrong_hit: oval=%0d score=%0d want %0d 0", oval_select, score, h);
    end
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    checks++; if (oval_select !== h || timer_clear !== 1'b0) begin
      failures++; $display("FAIL start_in_play: oval=%0d clear=%b want %0d 0", oval_select, timer_clear, h);
    end
    model_score = 1;
    sb_q.push_back(model_score);
    hit_btn = hole_bit(h);
    tick();
    hit_btn = '0;
    checks++; if (score !== 4'(sb_q.pop_front())) begin failures++; $display("FAIL hit_score: got %0d want 1", score); end
    checks++; if (oval_select !== 3'd0) begin failures++; $display("FAIL hit_clears: got %0d want 0", oval_select); end
  endtask

  task automatic test_pause();
    logic [2:0] h;
    int len = 0;
    wait_oval(1'b1, "pause_wait");
    h = oval_select;
    repeat (2) tick();
    pause_btn = 1'b1;
    tick();
    sb_q.push_back(6);
    for (int i = 0; i < 50; i++) begin
      checks++; if ({pause, enable, oval_select, score} !== {2'b11, h, 4'(model_score)}) begin
        failures++; $display("FAIL paused_hold[%0d]: pause=%b en=%b oval=%0d score=%0d want 1 1 %0d %0d",
                             i, pause, enable, oval_select, score, h, model_score);
      end
      hit_btn = (i % 2 == 0) ? (5'($urandom_range(1, 31)) | hole_bit(h)) : 5'd0;
      tick();
    end
    hit_btn = '0;
    pause_btn = 1'b0;
    tick();
    checks++; if (pause !== 1'b1) begin failures++; $display("FAIL pause_release: got %b want 1", pause); end
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    while (oval_select == h && pause == 1'b0 && len < 50) begin len++; tick(); end
    checks++; if (len !== sb_q.pop_front()) begin failures++; $display("FAIL resume_len: got %0d want 6", len); end
    checks++; if (score !== 4'(model_score)) begin failures++; $display("FAIL pause_score: got %0d want %0d", score, model_score); end
  endtask

  task automatic test_saturate();
    logic [2:0] h;
    for (int i = 0; i < 20; i++) begin
      wait_oval(1'b1, "sat_wait");
      h = oval_select;
      tick();
      model_score = (model_score == 15) ? 15 : model_score + 1;
      sb_q.push_back(model_score);
      hit_btn = hole_bit(h) | ((i % 3 == 0) ? hole_bit((h == 3'd5) ? 3'd1 : h + 3'd1) : 5'd0);
      tick();
      hit_btn = '0;
      checks++; if (score !== 4'(sb_q.pop_front()) || oval_select !== 3'd0) begin
        failures++; $display("FAIL sat_hit[%0d]: score=%0d oval=%0d want %0d 0", i, score, oval_select, model_score);
      end
    end
  endtask

  task automatic test_spawn_sequence();
    logic [2:0] prev = 3'd0, v;
    logic [5:0] seen = '0;
    for (int i = 0; i < 200; i++) begin
      wait_oval(1'b1, "seq_wait");
      v = oval_select;
      checks++; if (v < 3'd1 || v > 3'd5 || v == prev) begin
        failures++; $display("FAIL spawn_seq[%0d]: got %0d prev %0d want 1..5 and different", i, v, prev);
      end
      seen[v] = 1'b1;
      prev = v;
      wait_oval(1'b0, "seq_gap");
    end
    checks++; if (seen !== 6'b111110) begin failures++; $display("FAIL holes_seen: got %b want 111110", seen); end
  endtask

  task automatic test_over_from_pause();
    wait_oval(1'b1, "over_wait");
    repeat (2) tick();
    pause_btn = 1'b1;
    tick();
    pause_btn = 1'b0;
    checks++; if (pause !== 1'b1) begin failures++; $display("FAIL over_paused: got %b want 1", pause); end
    timer_done = 1'b1;
    tick();
    timer_done = 1'b0;
    checks++; if ({game_over, enable, pause, oval_select} !== 6'b100000) begin
      failures++; $display("FAIL over_state: over=%b en=%b pause=%b oval=%0d want 1 0 0 0", game_over, enable, pause, oval_select);
    end
    checks++; if (score !== 4'(model_score)) begin failures++; $display("FAIL over_score: got %0d want %0d", score, model_score); end
    repeat (4) tick();
    checks++; if (game_over !== 1'b1 || oval_select !== 3'd0) begin
      failures++; $display("FAIL over_hold: over=%b oval=%0d want 1 0", game_over, oval_select);
    end
    model_score = 0;
    start_btn = 1'b1;
    tick();
    start_btn = 1'b0;
    checks++; if ({timer_clear, enable, game_over} !== 3'b110 || score !== 4'(model_score)) begin
      failures++; $display("FAIL restart: clear=%b en=%b over=%b score=%0d want 1 1 0 0", timer_clear, enable, game_over, score);
    end
    tick();
    checks++; if (oval_select < 3'd1 || oval_select > 3'd5 || timer_clear !== 1'b0) begin
      failures++; $display("FAIL restart_spawn: oval=%0d clear=%b want 1..5 0", oval_select, timer_clear);
    end
  endtask

  task automatic test_reset_midgame();
    wait_oval(1'b0, "mid_gap");
    wait_oval(1'b1, "mid_wait");
    tick();
    hit_btn = hole_bit(oval_select);
    tick();
    hit_btn = '0;
    checks++; if (score !== 4'd1) begin failures++; $display("FAIL mid_score: got %0d want 1", score); end
    wait_oval(1'b1, "mid_wait2");
    #2 rst = 1'b0;
    #1;
    checks++; if ({oval_select, score, enable, pause, timer_clear, game_over} !== 11'd0) begin
      failures++; $display("FAIL async_reset: oval=%0d score=%0d en=%b pause=%b clear=%b over=%b want all 0",
                           oval_select, score, enable, pause, timer_clear, game_over);
    end
    tick();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (timer_clear !== 1'b0 || enable !== 1'b0) begin
      failures++; $display("FAIL reset_no_clear: clear=%b en=%b want 0 0", timer_clear, enable);
    end
  endtask

  initial begin
    test_reset();
    test_start_timing();
    test_hit();
    test_pause();
    test_saturate();
    test_spawn_sequence();
    test_over_from_pause();
    test_reset_midgame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_game_ctrl.md
# mole_game_ctrl

Game-control FSM for the whack-a-mole display path. It sits directly upstream of the combined VGA display stage. It chooses which of the five ovals holds the mole, times each mole appearance and the gap after it, scores player hits, and handles pause. It drives the display's `oval_select`, `score`, `enable`, `pause` and timer-clear (`G`) inputs and consumes its `timer_done_signal`.

## Interface
- `UP_CYCLES`, 50_000_000: clock cycles a mole stays up (legal range 2 to 2^27-1).
- `GAP_CYCLES`, 12_500_000: clock cycles with no mole between appearances (legal range 2 to 2^27-1).
- `LFSR_SEED`, 8'hA5: LFSR reset value; must be non-zero.
- `clk`  in  1  system clock, same clock as the display stage.
- `rst`  in  1  reset, asynchronous, active-low.
- `start_btn`  in  1  debounced start button level.
- `pause_btn`  in  1  debounced pause-toggle button level.
- `hit_btn`  in  5  debounced hole buttons; bit i corresponds to oval i+1.
- `timer_done`  in  1  game-timer expiry level from the display stage.
- `oval_select`  out  3  mole position: 0 = none, 1..5 = oval.
- `score`  out  4  hit count, saturating.
- `enable`  out  1  game-timer run enable.
- `pause`  out  1  paused indicator, also freezes the game timer.
- `timer_clear`  out  1  one-cycle pulse that restarts the game timer (drives `G`).
- `game_over`  out  1  high while in OVER.

## Operation
- Rising-edge detectors on `start_btn`, `pause_btn` and each `hit_btn` bit, each using one registered previous-value flop. An edge is a one-cycle event.
- 8-bit Fibonacci LFSR, taps 8,6,5,4. It advances every cycle out of reset and never stalls.
- States and transitions:
  - IDLE
    - start edge: clear score, pulse `timer_clear`, assert `enable`, go to SPAWN.
  - SPAWN (1 cycle)
    - candidate = (lfsr mod 5) + 1.
    - If candidate equals the previous hole, use candidate+1, wrapping 5 to 1.
    - Load `oval_select` and the previous-hole register with the result, load the counter, go to UP.
  - UP
    - Counter decrements each cycle.
    - Hit edge on bit `oval_select`-1: score+1 (stays at 15), `oval_select`=0, go to GAP. This applies even when other bits also have edges that cycle.
    - Edges on other bits only: no effect.
    - Counter expiry with no hit: `oval_select`=0, go to GAP. No score change.
  - GAP
    - Counter expiry: go to SPAWN.
  - PAUSED
    - Entered from UP or GAP on a pause edge.
    - Counter, `oval_select`, score and the return state are all frozen.
    - Hit edges are ignored.
    - Pause edge: resume the saved state with the remaining count.
  - OVER
    - `oval_select`=0, `enable`=0, score held, `game_over`=1.
    - start edge: same action as from IDLE.
- Priority inside UP, GAP and PAUSED, highest first: `timer_done`, then pause edge, then correct hit, then counter expiry.
  - `timer_done`=1 in any of these states goes to OVER, including while paused.
- `pause`=1 exactly while in PAUSED.
- `enable`=1 in SPAWN, UP, GAP and PAUSED.
- A start edge during play is ignored.
- Counter is 27 bits.
  - Loaded with `UP_CYCLES`-1 in SPAWN and with `GAP_CYCLES`-1 on entry to GAP.
  - Expiry means the counter equals 0 in UP or GAP.
- Previous-hole register resets to 0, so the first spawn is never remapped.

## Timing
- Reset values: `oval_select`=0, `score`=0, `enable`=0, `pause`=0, `timer_clear`=0, `game_over`=0, state IDLE, LFSR=`LFSR_SEED`, edge-detector flops=0.
- Reset asserted mid-game returns everything to the reset values immediately; no `timer_clear` pulse is issued.
- Button edges act 1 cycle after the level rises, because of the edge register.
- start edge in IDLE or OVER:
  - next cycle: state SPAWN, `timer_clear`=1 for exactly that cycle, `enable`=1.
  - `oval_select` becomes non-zero the cycle after that.
- Mole visible for exactly `UP_CYCLES` cycles when not hit.
- After a hit, `oval_select`=0 on the next cycle.
- Gap lasts `GAP_CYCLES` cycles plus 1 SPAWN cycle.
- `timer_done` to `game_over`=1 takes 1 cycle.
- All outputs are registered.

## Test plan
- Reset, then start edge with UP_CYCLES=8, GAP_CYCLES=4:
  - `timer_clear` high for exactly 1 cycle.
  - `oval_select` in 1..5 two cycles after the edge and held for 8 cycles.
  - Then 0 for 5 cycles.
- Hit the correct hole 3 cycles into UP → `score` goes 0→1 and `oval_select`→0 next cycle. Hit a wrong hole → score unchanged and the mole stays.
- Score 20 correct hits → `score` saturates at 15.
- Pause 2 cycles into UP, hold for 50 cycles, hitting buttons meanwhile:
  - `pause`=1 and `oval_select` unchanged throughout; score unchanged.
  - After unpause, the mole remains up exactly 6 more cycles.
- Run 200 spawns → no two consecutive holes equal; every value is in 1..5.
- Assert `timer_done` while PAUSED → OVER: `game_over`=1, `enable`=0, `oval_select`=0, score retained. A start edge then restarts with `score`=0.
